// File: rtl/pulse_channel_gen_if.sv
// pulse_channel_gen_if: register write port into the pulse channel.
interface pulse_channel_gen_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pulse_channel_gen.sv
// pulse_channel_gen: NES-style square channel with timer, duty sequencer, envelope, sweep and length counter.
module pulse_channel_gen #(
  parameter int TICK_DIV        = 2,
  parameter int SWEEP_ONES_COMP = 0,
  parameter int OUT_W           = 4
) (
  input  logic             clk,
  input  logic             channel_reset,
  input  logic             channel_enable,
  input  logic             iEnvelope_clk,
  input  logic             iLength_clk,
  pulse_channel_gen_if.slave wr,
  output logic [OUT_W-1:0] pulse,
  output logic             length_active
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10, 8'd254, 8'd20, 8'd2, 8'd40, 8'd4, 8'd80, 8'd6,
    8'd160, 8'd8, 8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12, 8'd16, 8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30};
  logic [PW-1:0] pre;
  logic [1:0]  duty;
  logic        loop, cnst, sw_en, sw_neg, sweep_reload, env_start;
  logic [3:0]  env_v, decay, env_div, vol;
  logic [2:0]  sw_p, sw_s, sdiv, step;
  logic [10:0] period, timer;
  logic [7:0]  length;
  logic [11:0] delta, target;
  logic        w0, w1, w2, w3, tick, mute, duty_bit, sweep_upd;
  always_comb begin
    w0 = wr.wr_en && wr.wr_addr == 2'd0;
    w1 = wr.wr_en && wr.wr_addr == 2'd1;
    w2 = wr.wr_en && wr.wr_addr == 2'd2;
    w3 = wr.wr_en && wr.wr_addr == 2'd3;
    tick = pre == PW'(TICK_DIV - 1);
    delta = {1'b0, period} >> sw_s;
    target = sw_neg ? {1'b0, period} - delta - 12'(SWEEP_ONES_COMP) : {1'b0, period} + delta;
    mute = period < 11'd8 || target[11];
    vol = cnst ? env_v : decay;
    duty_bit = duty == 2'd0 ? step == 3'd7 : duty == 2'd1 ? step >= 3'd6 : duty == 2'd2 ? step[2] : step <= 3'd5;
    sweep_upd = iLength_clk && sdiv == '0 && sw_en && sw_s != '0 && !mute;
  end
  always_ff @(posedge clk) begin
    if (channel_reset) begin
      pre <= '0;
      timer <= '0;
      step <= '0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) timer <= timer == '0 ? period : timer - 11'd1;
      if (w3) step <= '0;
      else if (tick && timer == '0) step <= step + 3'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (channel_reset) begin
      {duty, loop, cnst, env_v} <= '0;
      {sw_en, sw_p, sw_neg, sw_s} <= '0;
      period <= '0;
      sweep_reload <= 1'b0;
      sdiv <= '0;
    end else begin
      if (w0) {duty, loop, cnst, env_v} <= wr.wr_data;
      if (w1) {sw_en, sw_p, sw_neg, sw_s} <= wr.wr_data;
      // register writes take priority over a coincident sweep update
      if (w2) period[7:0] <= wr.wr_data;
      else if (w3) period[10:8] <= wr.wr_data[2:0];
      else if (sweep_upd) period <= target[10:0];
      if (w1) sweep_reload <= 1'b1;
      else if (iLength_clk && (sdiv == '0 || sweep_reload)) sweep_reload <= 1'b0;
      if (iLength_clk) sdiv <= (sdiv == '0 || sweep_reload) ? sw_p : sdiv - 3'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (channel_reset) begin
      env_start <= 1'b0;
      decay <= '0;
      env_div <= '0;
    end else begin
      if (w3) env_start <= 1'b1;
      else if (iEnvelope_clk) env_start <= 1'b0;
      if (iEnvelope_clk) begin
        if (env_start) begin
          decay <= 4'hF;
          env_div <= env_v;
        end else if (env_div == '0) begin
          env_div <= env_v;
          decay <= decay != '0 ? decay - 4'd1 : loop ? 4'hF : decay;
        end else env_div <= env_div - 4'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (channel_reset || !channel_enable) length <= '0;
    else if (w3) length <= LEN_TABLE[wr.wr_data[7:3]];
    else if (iLength_clk && length != '0 && !loop) length <= length - 8'd1;
  end
  always_ff @(posedge clk) begin
    if (channel_reset) begin
      pulse <= '0;
      length_active <= 1'b0;
    end else begin
      pulse <= (length != '0 && duty_bit && !mute) ? OUT_W'(vol) << (OUT_W - 4) : '0;
      length_active <= length != '0;
    end
  end
endmodule

// File: tb/tb_pulse_channel_gen.sv
// tb_pulse_channel_gen: directed and random stimulus against a behavioural model of both sweep flavours.
module tb_pulse_channel_gen;
  localparam int TD = 2;
  logic clk = 1'b0;
  logic channel_reset = 1'b1, channel_enable = 1'b0, env_clk = 1'b0, len_clk = 1'b0;
  logic [3:0] pulse0;
  logic [4:0] pulse1;
  logic act0, act1;
  int n_checks = 0, n_fail = 0;
  pulse_channel_gen_if bus ();
  pulse_channel_gen #(.TICK_DIV(TD), .SWEEP_ONES_COMP(1), .OUT_W(4)) u0 (
    .clk(clk), .channel_reset(channel_reset), .channel_enable(channel_enable),
    .iEnvelope_clk(env_clk), .iLength_clk(len_clk), .wr(bus),
    .pulse(pulse0), .length_active(act0));
  pulse_channel_gen #(.TICK_DIV(TD), .SWEEP_ONES_COMP(0), .OUT_W(5)) u1 (
    .clk(clk), .channel_reset(channel_reset), .channel_enable(channel_enable),
    .iEnvelope_clk(env_clk), .iLength_clk(len_clk), .wr(bus),
    .pulse(pulse1), .length_active(act1));
  always #5 clk = ~clk;
  int len_tab [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                       12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
  logic [7:0] duty_mask [4] = '{8'h80, 8'hC0, 8'hF0, 8'h3F};
  int m_duty[2], m_halt[2], m_const[2], m_v[2], m_sen[2], m_sp[2], m_neg[2], m_ss[2];
  int m_rel[2], m_period[2], m_timer[2], m_step[2], m_start[2], m_decay[2], m_ediv[2];
  int m_len[2], m_sdiv[2], m_pre[2], m_pulse[2], m_act[2];
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step(input int c);
    int d, tgt, mute, vol, upd, wa, wd;
    bit w[4];
    if (channel_reset) begin
      m_duty[c] = 0; m_halt[c] = 0; m_const[c] = 0; m_v[c] = 0; m_sen[c] = 0; m_sp[c] = 0;
      m_neg[c] = 0; m_ss[c] = 0; m_rel[c] = 0; m_period[c] = 0; m_timer[c] = 0; m_step[c] = 0;
      m_start[c] = 0; m_decay[c] = 0; m_ediv[c] = 0; m_len[c] = 0; m_sdiv[c] = 0; m_pre[c] = 0;
      m_pulse[c] = 0; m_act[c] = 0;
      return;
    end
    wa = int'(bus.wr_addr);
    wd = int'(bus.wr_data);
    for (int k = 0; k < 4; k++) w[k] = bus.wr_en && wa == k;
    d = m_period[c] >> m_ss[c];
    tgt = (m_neg[c] != 0 ? m_period[c] - d - (c == 0 ? 1 : 0) : m_period[c] + d) & 4095;
    mute = (m_period[c] < 8 || tgt > 2047) ? 1 : 0;
    vol = m_const[c] != 0 ? m_v[c] : m_decay[c];
    m_pulse[c] = (m_len[c] != 0 && duty_mask[m_duty[c]][m_step[c]] && mute == 0) ? vol << c : 0;
    m_act[c] = m_len[c] != 0 ? 1 : 0;
    if (m_pre[c] == TD - 1) begin
      m_pre[c] = 0;
      if (m_timer[c] == 0) begin
        m_timer[c] = m_period[c];
        m_step[c] = (m_step[c] + 1) % 8;
      end else m_timer[c]--;
    end else m_pre[c]++;
    if (w[3]) m_step[c] = 0;
    if (env_clk) begin
      if (m_start[c] != 0) begin
        m_start[c] = 0; m_decay[c] = 15; m_ediv[c] = m_v[c];
      end else if (m_ediv[c] == 0) begin
        m_ediv[c] = m_v[c];
        if (m_decay[c] > 0) m_decay[c]--;
        else if (m_halt[c] != 0) m_decay[c] = 15;
      end else m_ediv[c]--;
    end
    if (w[3]) m_start[c] = 1;
    if (!channel_enable) m_len[c] = 0;
    else if (w[3]) m_len[c] = len_tab[wd >> 3];
    else if (len_clk && m_len[c] > 0 && m_halt[c] == 0) m_len[c]--;
    upd = (len_clk && m_sdiv[c] == 0 && m_sen[c] != 0 && m_ss[c] != 0 && mute == 0) ? 1 : 0;
    if (w[2]) m_period[c] = (m_period[c] & 'h700) | wd;
    else if (w[3]) m_period[c] = (m_period[c] & 'hFF) | ((wd & 7) << 8);
    else if (upd != 0) m_period[c] = tgt & 2047;
    if (len_clk) begin
      if (m_sdiv[c] == 0 || m_rel[c] != 0) begin
        m_sdiv[c] = m_sp[c]; m_rel[c] = 0;
      end else m_sdiv[c]--;
    end
    if (w[1]) begin
      m_rel[c] = 1; m_sen[c] = (wd >> 7) & 1; m_sp[c] = (wd >> 4) & 7; m_neg[c] = (wd >> 3) & 1; m_ss[c] = wd & 7;
    end
    if (w[0]) begin
      m_duty[c] = wd >> 6; m_halt[c] = (wd >> 5) & 1; m_const[c] = (wd >> 4) & 1; m_v[c] = wd & 15;
    end
  endtask
  always @(posedge clk) for (int c = 0; c < 2; c++) model_step(c);
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check("pulse0", int'(pulse0), m_pulse[0]);
      check("pulse1", int'(pulse1), m_pulse[1]);
      check("active0", int'(act0), m_act[0]);
      check("active1", int'(act1), m_act[1]);
      check("decay", int'(u0.decay), m_decay[0]);
    end
  endtask
  task automatic wr(input int a, input int d);
    bus.wr_en = 1'b1;
    bus.wr_addr = a[1:0];
    bus.wr_data = d[7:0];
    cyc(1);
    bus.wr_en = 1'b0;
  endtask
  task automatic lpulse();
    len_clk = 1'b1;
    cyc(1);
    len_clk = 1'b0;
  endtask
  task automatic epulse();
    env_clk = 1'b1;
    cyc(1);
    env_clk = 1'b0;
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    cyc(2);
    check("rst_pulse", int'(pulse0), 0);
    check("rst_active", int'(act0), 0);
    channel_reset = 1'b0;
    channel_enable = 1'b1;
    wr(0, 'hBF); wr(2, 'h40); wr(3, 'h08);
    cyc(1200);
    check("note_active", int'(act0), 1);
    wr(0, 'h30); wr(0, 'h1F); wr(3, 'h18);
    cyc(3);
    lpulse();
    cyc(1);
    check("len_one_left", int'(act0), 1);
    lpulse();
    cyc(1);
    check("len_expired", int'(act0), 0);
    channel_enable = 1'b0;
    cyc(1);
    wr(3, 'h18);
    cyc(3);
    check("dis_active", int'(act0), 0);
    check("dis_pulse", int'(pulse0), 0);
    channel_enable = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      wr(0, pass == 0 ? 'h82 : 'hA2);
      wr(3, 'h08);
      epulse();
      check("env_start", int'(u0.decay), 15);
      repeat (60) begin
        epulse();
        cyc(1);
      end
    end
    wr(2, 'h00); wr(3, 'h01); wr(1, 'h89);
    cyc(2);
    lpulse();
    cyc(1);
    check("sweep_ones", int'(u0.period), 'h07F);
    check("sweep_twos", int'(u1.period), 'h080);
    wr(2, 'hF0); wr(3, 'h07); wr(1, 'h81);
    cyc(2);
    check("mute_pulse", int'(pulse0), 0);
    lpulse();
    cyc(1);
    check("mute_hold0", int'(u0.period), 'h7F0);
    check("mute_hold1", int'(u1.period), 'h7F0);
    wr(1, 'h00); wr(2, 'h07); wr(3, 'h00);
    cyc(300);
    check("short_mute", int'(pulse0), 0);
    wr(0, 'h1F); wr(2, 'h20);
    bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 8'h08; len_clk = 1'b1;
    cyc(1);
    bus.wr_en = 1'b0; len_clk = 1'b0;
    check("load_wins", int'(u0.length), 254);
    cyc(200);
    channel_reset = 1'b1;
    cyc(1);
    check("mid_rst_pulse", int'(pulse0), 0);
    check("mid_rst_active", int'(act0), 0);
    channel_reset = 1'b0;
    repeat (5000) begin
      channel_reset = $urandom_range(0, 799) == 0;
      if ($urandom_range(0, 299) == 0) channel_enable = !channel_enable;
      env_clk = $urandom_range(0, 19) == 0;
      len_clk = $urandom_range(0, 29) == 0;
      bus.wr_en = $urandom_range(0, 14) == 0;
      bus.wr_addr = 2'($urandom_range(0, 3));
      bus.wr_data = 8'($urandom) & (bus.wr_addr == 2'd3 ? 8'hF9 : 8'hFF);
      cyc(1);
    end
    channel_reset = 1'b0; env_clk = 1'b0; len_clk = 1'b0; bus.wr_en = 1'b0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_channel_gen.md
Name: pulse_channel_gen

Overview:
Self-contained, parametrised NES-style pulse (square) channel. It integrates the timer, 8-step duty sequencer, envelope, sweep unit and length counter, and is programmed through a write-strobe register port rather than static register inputs. SWEEP_ONES_COMP selects pulse-1 or pulse-2 sweep arithmetic. The mixer instantiates two copies; the frame sequencer supplies quarter/half-frame strobes.

Parameters:
TICK_DIV, 2, clk cycles per timer tick (internal prescaler, >=1)
SWEEP_ONES_COMP, 0, 1 = negate uses ones' complement (pulse 1); 0 = two's complement (pulse 2)
OUT_W, 4, output width, >=4; volume is left-shifted by OUT_W-4

Ports:
clk  in  1  system clock
channel_reset  in  1  synchronous active-high reset
channel_enable  in  1  status enable; low forces length counter to 0
iEnvelope_clk  in  1  quarter-frame strobe, one clk wide
iLength_clk  in  1  half-frame strobe, one clk wide; clocks length and sweep
wr_en  in  1  register write strobe
wr_addr  in  2  register select 0..3 ($4000..$4003)
wr_data  in  8  write data
pulse  out  OUT_W  channel sample
length_active  out  1  length counter != 0

Behaviour:
- Reset: all registers, counters, flags, step and prescaler = 0; pulse = 0, length_active = 0.
- Writes take effect at the clk edge where wr_en = 1. Addr0: duty[7:6], halt/loop[5], const[4], V[3:0]. Addr1: sweep en[7], P[6:4], neg[3], S[2:0]; sets sweep_reload. Addr2: period[7:0]. Addr3: period[10:8] = d[2:0]; step <= 0; env_start <= 1; if channel_enable, length <= LEN_TABLE[d[7:3]].
- LEN_TABLE: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Prescaler counts 0..TICK_DIV-1 and asserts tick on wrap. On tick: timer==0 -> timer <= period, step <= step+1 mod 8; else timer--. Timer is not reloaded by period writes.
- Duty output (high steps): duty0 = {7}; duty1 = {6,7}; duty2 = {4..7}; duty3 = {0..5}.
- Envelope on iEnvelope_clk:
  - env_start: clear env_start, decay <= 15, div <= V.
  - Otherwise div==0: div <= V; then decay>0 -> decay--, else if loop -> decay <= 15.
  - Otherwise div--.
  - vol = const ? V : decay.
- Length:
  - channel_enable low -> length <= 0 every cycle.
  - On iLength_clk with length!=0 and !halt -> length--.
  - Addr3 load in the same cycle wins over decrement.
- Sweep:
  - delta = period >> S.
  - target = neg ? period - delta - SWEEP_ONES_COMP : period + delta (12-bit).
  - mute = (period < 8) | (target > 2047). Computed combinationally every cycle, whether or not sweep is enabled.
  - On iLength_clk: if sdiv==0 && en && S!=0 && !mute -> period <= target[10:0]. Then if sdiv==0 || sweep_reload -> sdiv <= P, sweep_reload <= 0; else sdiv--.
  - If an addr2/addr3 write coincides with a sweep update, the write wins.
- Output, registered with 1-cycle latency:
  - pulse <= (length!=0 && duty_bit && !mute) ? vol << (OUT_W-4) : 0.
  - length_active <= (length!=0).
- Wrap: step 7 -> 0; decay 0 -> 15 only with loop; length never underflows.
- channel_reset mid-operation: everything returns to reset values next edge; pending env_start and sweep_reload are cleared.

Test Plan:
- Reset, enable=1, write addr0=$BF, addr2=$40, addr3=$08 (len idx1=254), TICK_DIV=2 -> pulse = 15 only during steps 4..7. Each step lasts 65 ticks = 130 clk. length_active = 1.
- Length: addr0=$30 is overridden by addr0=$1F (halt=0, const). Write addr3=$18 (idx3 -> 2), then two iLength_clk -> length_active drops after the 2nd. Repeat with channel_enable=0 before the write -> no load, pulse stays 0.
- Envelope: addr0=$82 (loop=0, V=2), write addr3, then iEnvelope_clk pulses -> decay 15 at 1st, decrements every 3rd pulse, holds 0. With addr0=$A2 it wraps 0 -> 15.
- Sweep negate: period=$100, addr1=$89 (en, P=0, neg, S=1), iLength_clk. With SWEEP_ONES_COMP=1 -> period $07F; with 0 -> $080.
- Mute: period=$7F0, addr1=$81 (add, S=1), so target $BE8 > 2047 -> pulse = 0 and period unchanged after iLength_clk. period=7 -> pulse = 0.
- Simultaneous: addr3 write and iLength_clk in the same cycle -> length = table value, not table-1. channel_reset asserted mid-note -> pulse = 0 and length_active = 0 the next cycle.
